spec_ctrl: RTL
==============

// Module: spec_ctrl
// PURPOSE
//  Sequencer for MIX special ops (C=5): NUM (F=0), CHAR (F=1), HLT (F=2).
//  Decodes F, launches the shared char or num conversion unit via start/stop handshake,
//  captures its result and issues one writeback of rA/rX to the register file.
//  Sits between the instruction decoder and the conversion datapaths; one op in flight.
// PARAMETERS
//  TIMEOUT   16  max cycles from unit start to unit stop before err is flagged
// PORTS
//  clk        in   1   system clock; all state changes on posedge
//  reset      in   1   synchronous, active-high reset
//  start      in   1   one-cycle pulse: decoder issues C=5 op
//  field      in   6   F field of the instruction
//  ra_in      in   30  rA magnitude (sign handled outside; unchanged by these ops)
//  rx_in      in   30  rX magnitude
//  char_start out  1   pulse to char unit
//  char_in    out  30  operand to char unit (registered ra_in)
//  char_stop  in   1   char unit done pulse
//  char_out   in   60  ten 6-bit char codes, MS digit in [59:54]
//  num_start  out  1   pulse to num unit
//  num_in     out  60  {rA,rX} char codes to num unit
//  num_stop   in   1   num unit done pulse
//  num_out    in   30  converted magnitude (mod 2^30)
//  wr_ra      out  1   one-cycle rA write enable
//  wr_rx      out  1   one-cycle rX write enable
//  ra_out     out  30  rA write data
//  rx_out     out  30  rX write data
//  busy       out  1   high from cycle after start until done
//  done       out  1   one-cycle pulse: op retired
//  halt       out  1   level; set by HLT, cleared only by reset
//  err        out  1   one-cycle pulse with done: illegal F or unit timeout
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; operand regs, timeout counter cleared.
//  States: IDLE, LAUNCH, WAIT_CHAR, WAIT_NUM, WB, HALTED.
//  IDLE: start=1 latches field, ra_in, rx_in -> LAUNCH; start ignored in every other state.
//  LAUNCH (1 cycle): F=1 -> char_start=1, ->WAIT_CHAR; F=0 -> num_start=1, ->WAIT_NUM;
//   F=2 -> halt=1, done=1 -> HALTED; other F -> done=1, err=1 -> IDLE, no writes.
//  char_in/num_in driven from latched operands, stable from LAUNCH until WB.
//  WAIT_*: counter increments each cycle; stop pulse from the selected unit captures
//   result -> WB. Stop from the non-selected unit ignored. Counter reaching TIMEOUT
//   before stop -> done=1, err=1, no writes -> IDLE.
//  Capture: CHAR -> ra_out=char_out[59:30], rx_out=char_out[29:0]; NUM -> ra_out=num_out.
//  WB (1 cycle): CHAR wr_ra=wr_rx=1; NUM wr_ra=1 only; done=1 -> IDLE.
//  Latency CHAR: start -> done = unit latency + 3 cycles; HLT/illegal: 2 cycles.
//  Stop in same cycle as timeout reaching TIMEOUT: stop wins, normal writeback.
//  HALTED: absorbing; busy=0, halt=1; only reset leaves.
//  Reset mid-op: IDLE next cycle, no write/done issued; late unit stop ignored in IDLE.
//  done asserted exactly once per accepted start; wr_* never without done.
// STRUCTURE
//  Package mix_pkg: OP_SPEC=6'd5, F_NUM=0, F_CHAR=1, F_HLT=2, state encoding, CHAR_BIAS=30.
//  Sub-module spec_watchdog: TIMEOUT counter with clear/enable/expired; rest is one FSM.
// TESTING
//  CHAR ra_in=12977700 -> wr_ra=wr_rx=1, ra_out=codes 30,30,31,32,39; rx_out=37,37,37,30,30.
//  NUM rA=30,30,31,32,39 rX=37,37,37,30,30 (stub) -> wr_ra=1, ra_out=12977700, wr_rx=0.
//  F=2 -> halt=1, done=1 two cycles after start; later start ignored, busy stays 0.
//  F=7 -> done=1,err=1, no wr_*, no unit start; stub never stops -> err after TIMEOUT=16.
//  start during WAIT_CHAR ignored; reset in WAIT_CHAR then stub stop -> no done, no writes.

Source files
------------

// File: rtl/mix_pkg.sv
// Shared constants and state encoding for the MIX special-op (C=5) sequencer.
package mix_pkg;

   localparam logic [5:0] OP_SPEC = 6'd5;
   localparam logic [5:0] F_NUM   = 6'd0;
   localparam logic [5:0] F_CHAR  = 6'd1;
   localparam logic [5:0] F_HLT   = 6'd2;

   // Character code of decimal digit 0; digit d maps to CHAR_BIAS + d.
   localparam int CHAR_BIAS = 30;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_CHAR,
      S_WAIT_NUM,
      S_WB,
      S_HALTED
   } state_t;

endpackage

// File: rtl/spec_ctrl_if.sv
// Start/stop handshake and operand/result buses to the char and num conversion units.
interface spec_ctrl_if;

   logic        char_start;
   logic [29:0] char_in;
   logic        char_stop;
   logic [59:0] char_out;
   logic        num_start;
   logic [59:0] num_in;
   logic        num_stop;
   logic [29:0] num_out;

   // Sequencer side
   modport master (
      output char_start, char_in, num_start, num_in,
      input  char_stop, char_out, num_stop, num_out
   );

   // Conversion-unit side
   modport slave (
      input  char_start, char_in, num_start, num_in,
      output char_stop, char_out, num_stop, num_out
   );

endinterface

// File: rtl/spec_watchdog.sv
// Cycle counter bounding how long the sequencer waits for a unit stop pulse.
module spec_watchdog #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Count enabled wait cycles; clear whenever no unit is being waited on.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Fires in the wait cycle whose increment brings the count to TIMEOUT.
   assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/spec_ctrl.sv
// Sequencer for MIX C=5 special ops: NUM, CHAR and HLT.
module spec_ctrl
   import mix_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [5:0]      field,
   input  logic [29:0]     ra_in,
   input  logic [29:0]     rx_in,
   spec_ctrl_if.master     cu,
   output logic            wr_ra,
   output logic            wr_rx,
   output logic [29:0]     ra_out,
   output logic [29:0]     rx_out,
   output logic            busy,
   output logic            done,
   output logic            halt,
   output logic            err
);

   state_t      state_q, state_d;
   logic [5:0]  field_q, field_d;
   logic [29:0] ra_q, ra_d;
   logic [29:0] rx_q, rx_d;
   logic [29:0] ra_out_q, ra_out_d;
   logic [29:0] rx_out_q, rx_out_d;
   logic        char_start_q, char_start_d;
   logic        num_start_q, num_start_d;
   logic        wr_ra_q, wr_ra_d;
   logic        wr_rx_q, wr_rx_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        halt_q, halt_d;
   logic        wd_clr, wd_en, wd_expired;

   spec_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk       (clk),
      .rst_i     (reset),
      .clr_i     (wd_clr),
      .en_i      (wd_en),
      .expired_o (wd_expired)
   );

   // State and registered outputs; every output is registered so pulses line up with the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         field_q      <= '0;
         ra_q         <= '0;
         rx_q         <= '0;
         ra_out_q     <= '0;
         rx_out_q     <= '0;
         char_start_q <= 1'b0;
         num_start_q  <= 1'b0;
         wr_ra_q      <= 1'b0;
         wr_rx_q      <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         halt_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         field_q      <= field_d;
         ra_q         <= ra_d;
         rx_q         <= rx_d;
         ra_out_q     <= ra_out_d;
         rx_out_q     <= rx_out_d;
         char_start_q <= char_start_d;
         num_start_q  <= num_start_d;
         wr_ra_q      <= wr_ra_d;
         wr_rx_q      <= wr_rx_d;
         done_q       <= done_d;
         err_q        <= err_d;
         halt_q       <= halt_d;
      end
   end

   // Next-state and next-output decode; pulses default low, data holds.
   always_comb begin
      state_d      = state_q;
      field_d      = field_q;
      ra_d         = ra_q;
      rx_d         = rx_q;
      ra_out_d     = ra_out_q;
      rx_out_d     = rx_out_q;
      char_start_d = 1'b0;
      num_start_d  = 1'b0;
      wr_ra_d      = 1'b0;
      wr_rx_d      = 1'b0;
      done_d       = 1'b0;
      err_d        = 1'b0;
      halt_d       = halt_q;
      wd_en        = (state_q == S_WAIT_CHAR) || (state_q == S_WAIT_NUM);
      wd_clr       = !wd_en;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               field_d = field;
               ra_d    = ra_in;
               rx_d    = rx_in;
               state_d = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            case (field_q)
               F_CHAR: begin
                  char_start_d = 1'b1;
                  state_d      = S_WAIT_CHAR;
               end
               F_NUM: begin
                  num_start_d = 1'b1;
                  state_d     = S_WAIT_NUM;
               end
               F_HLT: begin
                  halt_d  = 1'b1;
                  done_d  = 1'b1;
                  state_d = S_HALTED;
               end
               default: begin
                  done_d  = 1'b1;
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            endcase
         end
         S_WAIT_CHAR: begin
            // A stop arriving in the expiry cycle still wins.
            if (cu.char_stop) begin
               ra_out_d = cu.char_out[59:30];
               rx_out_d = cu.char_out[29:0];
               wr_ra_d  = 1'b1;
               wr_rx_d  = 1'b1;
               done_d   = 1'b1;
               state_d  = S_WB;
            end else if (wd_expired) begin
               done_d  = 1'b1;
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_WAIT_NUM: begin
            if (cu.num_stop) begin
               ra_out_d = cu.num_out;
               wr_ra_d  = 1'b1;
               done_d   = 1'b1;
               state_d  = S_WB;
            end else if (wd_expired) begin
               done_d  = 1'b1;
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_WB:     state_d = S_IDLE;
         S_HALTED: state_d = S_HALTED;
         default:  state_d = S_IDLE;
      endcase
   end

   assign cu.char_start = char_start_q;
   assign cu.char_in    = ra_q;
   assign cu.num_start  = num_start_q;
   assign cu.num_in     = {ra_q, rx_q};
   assign wr_ra         = wr_ra_q;
   assign wr_rx         = wr_rx_q;
   assign ra_out        = ra_out_q;
   assign rx_out        = rx_out_q;
   assign done          = done_q;
   assign err           = err_q;
   assign halt          = halt_q;
   assign busy          = (state_q == S_LAUNCH) || (state_q == S_WAIT_CHAR) || (state_q == S_WAIT_NUM);

endmodule
